// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receiver through OFF/SETTLE/RUN, buffers bytes in a FIFO, tracks sticky flags and irq.
// Define UART_RX_CTRL_TIMEOUT_EN to add the idle-timeout counter and tmo_flag.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int PAYLOAD_BITS = 8,
  parameter int SETTLE_BITS = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_wr,
  input  logic                    cfg_enable,
  input  logic [9:0]              cfg_divider,
  input  logic [LW-1:0]           cfg_thresh,
  output logic                    rx_en,
  output logic [9:0]              rx_divider,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rd_valid,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  input  logic                    rd_ready,
  input  logic                    clr_flags,
  output logic [LW-1:0]           level,
  output logic                    ovf_flag,
  output logic                    brk_flag,
  output logic                    tmo_flag,
  output logic                    irq
);
  localparam int SW = $clog2(SETTLE_BITS + 1);
  typedef enum logic [1:0] {OFF, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic [9:0] div_q, div_d, tick_q, tick_d;
  logic [LW-1:0] thresh_q, thresh_d, level_q, level_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic ovf_q, ovf_d, brk_q, brk_d, tmo_q, tmo_d;
  logic tick, accept, full, push, pop, tmo_set;
  always_comb begin
    tick = state_q != OFF && tick_q == div_q;
    accept = state_q == RUN && rx_valid && !cfg_wr;
    full = level_q == LW'(FIFO_DEPTH);
    pop = level_q != '0 && rd_ready && !cfg_wr;
    push = accept && !rx_break && (!full || pop);
    state_d = cfg_wr ? (cfg_enable ? SETTLE : OFF)
            : (state_q == SETTLE && tick && settle_q == SW'(SETTLE_BITS - 1)) ? RUN : state_q;
    div_d = cfg_wr ? cfg_divider : div_q;
    thresh_d = cfg_wr ? cfg_thresh : thresh_q;
    tick_d = (cfg_wr || state_q == OFF || tick) ? '0 : tick_q + 10'd1;
    settle_d = (cfg_wr || state_q != SETTLE) ? '0 : tick ? settle_q + 1'b1 : settle_q;
    wr_ptr_d = cfg_wr ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = cfg_wr ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = cfg_wr ? '0 : level_q + LW'(push) - LW'(pop);
    // A set event in the same cycle as clr_flags keeps the flag set.
    ovf_d = (accept && !rx_break && full && !pop) || (ovf_q && !clr_flags);
    brk_d = (accept && rx_break) || (brk_q && !clr_flags);
    tmo_d = tmo_set || (tmo_q && !clr_flags);
  end
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TMO_TICKS = 4 * (PAYLOAD_BITS + 2);
  localparam int TW = $clog2(TMO_TICKS + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  always_comb begin
    tmo_cnt_d = (cfg_wr || push || pop || level_q == '0 || state_q != RUN) ? '0
              : (tick && tmo_cnt_q != TW'(TMO_TICKS)) ? tmo_cnt_q + 1'b1 : tmo_cnt_q;
    tmo_set = tmo_cnt_d == TW'(TMO_TICKS) && tmo_cnt_q != TW'(TMO_TICKS);
  end
  always_ff @(posedge clk) tmo_cnt_q <= !resetn ? '0 : tmo_cnt_d;
`else
  assign tmo_set = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= OFF;
      div_q <= '0;
      thresh_q <= '0;
      tick_q <= '0;
      settle_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      brk_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      thresh_q <= thresh_d;
      tick_q <= tick_d;
      settle_q <= settle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      brk_q <= brk_d;
      tmo_q <= tmo_d;
    end
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end
  assign rx_en = state_q != OFF;
  assign rx_divider = div_q;
  assign rd_valid = level_q != '0;
  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level = level_q;
  assign ovf_flag = ovf_q;
  assign brk_flag = brk_q;
  assign tmo_flag = tmo_q;
  assign irq = ovf_q || brk_q || tmo_q || (thresh_q != '0 && level_q >= thresh_q);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl with default parameters.
module tb_uart_rx_ctrl;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic TMO = 1'b1;
`else
  localparam logic TMO = 1'b0;
`endif
  logic clk = 0, resetn = 0, cfg_wr = 0, cfg_enable = 0, rx_valid = 0, rx_break = 0, rd_ready = 0, clr_flags = 0;
  logic [9:0] cfg_divider = '0;
  logic [3:0] cfg_thresh = '0;
  logic [7:0] rx_data = '0;
  logic rx_en, rd_valid, ovf_flag, brk_flag, tmo_flag, irq;
  logic [9:0] rx_divider;
  logic [7:0] rd_data;
  logic [3:0] level;
  int errors = 0, checks = 0;
  uart_rx_ctrl dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_enable(cfg_enable), .cfg_divider(cfg_divider),
    .cfg_thresh(cfg_thresh), .rx_en(rx_en), .rx_divider(rx_divider), .rx_valid(rx_valid),
    .rx_break(rx_break), .rx_data(rx_data), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .clr_flags(clr_flags), .level(level), .ovf_flag(ovf_flag), .brk_flag(brk_flag), .tmo_flag(tmo_flag), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cfg(input logic e, input logic [9:0] d, input logic [3:0] t);
    cfg_wr = 1; cfg_enable = e; cfg_divider = d; cfg_thresh = t;
    @(negedge clk);
    cfg_wr = 0;
  endtask
  task automatic rx(input logic [7:0] d, input logic b);
    rx_valid = 1; rx_data = d; rx_break = b;
    @(negedge clk);
    rx_valid = 0; rx_break = 0;
  endtask
  task automatic pop;
    rd_ready = 1;
    @(negedge clk);
    rd_ready = 0;
  endtask
  task automatic clr;
    clr_flags = 1;
    @(negedge clk);
    clr_flags = 0;
  endtask
  initial begin
    cyc(3);
    check("rst_rx_en", rx_en, 0);
    check("rst_div", rx_divider, 0);
    check("rst_level", level, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_flags", {ovf_flag, brk_flag, tmo_flag}, 0);
    check("rst_irq", irq, 0);
    resetn = 1;
    cyc(1);
    cfg(1, 10'd9, 4'd0);
    check("en_rx_en", rx_en, 1);
    check("en_div", rx_divider, 9);
    cyc(100);
    rx(8'hEE, 0);
    check("settle_ign_early", level, 0);
    cyc(53);
    rx(8'hEE, 0);
    check("settle_ign_late", level, 0);
    cyc(8);
    rx(8'hA5, 0);
    check("run_accept_level", level, 1);
    check("run_accept_data", rd_data, 8'hA5);
    pop();
    check("run_pop_empty", rd_valid, 0);
    rx(8'h11, 0); rx(8'h22, 0); rx(8'h33, 0);
    check("fifo3_level", level, 3);
    check("fifo3_head", rd_data, 8'h11);
    pop();
    check("fifo_pop1_data", rd_data, 8'h22);
    check("fifo_pop1_level", level, 2);
    pop();
    check("fifo_pop2_data", rd_data, 8'h33);
    check("fifo_pop2_level", level, 1);
    pop();
    check("fifo_pop3_level", level, 0);
    check("fifo_pop3_valid", rd_valid, 0);
    for (int i = 0; i < 9; i++) rx(8'h40 + 8'(i), 0);
    check("full_level", level, 8);
    check("full_ovf", ovf_flag, 1);
    check("full_irq", irq, 1);
    check("full_head", rd_data, 8'h40);
    clr();
    check("clr_ovf", ovf_flag, 0);
    check("clr_irq", irq, 0);
    rd_ready = 1;
    rx(8'h50, 0);
    rd_ready = 0;
    check("fullpp_level", level, 8);
    check("fullpp_ovf", ovf_flag, 0);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rd_data, i < 7 ? 8'h41 + 8'(i) : 8'h50);
      pop();
    end
    check("drain_level", level, 0);
    rx(8'h00, 1);
    check("brk_level", level, 0);
    check("brk_flag", brk_flag, 1);
    check("brk_irq", irq, 1);
    clr_flags = 1;
    rx(8'h00, 1);
    clr_flags = 0;
    check("brk_clr_race", brk_flag, 1);
    clr();
    check("brk_cleared", brk_flag, 0);
    rx(8'h00, 1);
    for (int i = 0; i < 5; i++) rx(8'h60 + 8'(i), 0);
    check("mid_level5", level, 5);
    cfg(1, 10'd9, 4'd3);
    check("mid_flush_level", level, 0);
    check("mid_flush_valid", rd_valid, 0);
    check("mid_brk_kept", brk_flag, 1);
    check("mid_rx_en", rx_en, 1);
    rx(8'h77, 0);
    check("mid_settle_ign", level, 0);
    cyc(170);
    clr();
    rx(8'h01, 0); rx(8'h02, 0);
    check("thr_below_irq", irq, 0);
    rx(8'h03, 0);
    check("thr_at_irq", irq, 1);
    pop();
    check("thr_drop_irq", irq, 0);
    pop(); pop();
    check("tmo_pre_level", level, 0);
    rx(8'h90, 0);
    cyc(380);
    check("tmo_early", tmo_flag, 0);
    cyc(40);
    check("tmo_hit", tmo_flag, TMO);
    check("tmo_irq", irq, TMO);
    pop();
    clr();
    rx(8'h91, 0);
    cyc(300);
    pop();
    cyc(200);
    check("tmo_popped", tmo_flag, 0);
    cfg(0, 10'd3, 4'd0);
    check("dis_rx_en", rx_en, 0);
    check("dis_div", rx_divider, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
